// File: rtl/nes_dual_pad_scheduler.sv
// Two-pad NES controller reader: one latch/pulse pair, two data lines, one read per frame.
// Both button bytes commit together; newly pressed bits and frame overruns are reported.
module nes_dual_pad_scheduler #(
    parameter int unsigned CLK_HZ   = 40000000,
    parameter int unsigned LATCH_US = 12,
    parameter int unsigned HALF_US  = 6
) (
    input  logic       pixelClock,
    input  logic       reset,
    input  logic       vSyncStart,
    input  logic [1:0] padData,
    output logic       padLatch,
    output logic       padPulse,
    output logic [7:0] buttons0,
    output logic [7:0] buttons1,
    output logic [7:0] pressed0,
    output logic [7:0] pressed1,
    output logic       frameValid,
    output logic       busy,
    output logic       overrun
);

    localparam int unsigned CNT_W      = 16;
    localparam int unsigned LATCH_CLKS = CLK_HZ / 1000000 * LATCH_US;
    localparam int unsigned HALF_CLKS  = CLK_HZ / 1000000 * HALF_US;
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CLKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CLKS - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(2 * HALF_CLKS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LATCH  = 2'd1,
        S_SHIFT  = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_bit;
    logic [2:0]       w_bit_nxt;
    logic             w_latch_nxt;
    logic             w_pulse_nxt;
    logic             w_capture;
    logic             w_commit;

    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [7:0]       r_shadow0;
    logic [7:0]       r_shadow1;
    logic             r_pad_latch;
    logic             r_pad_pulse;
    logic [7:0]       r_buttons0;
    logic [7:0]       r_buttons1;
    logic [7:0]       r_pressed0;
    logic [7:0]       r_pressed1;
    logic             r_frame_valid;
    logic             r_busy;
    logic             r_overrun;

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (vSyncStart) w_state_nxt = S_LATCH;
            S_LATCH:  if (r_cnt == LATCH_LAST) w_state_nxt = S_SHIFT;
            S_SHIFT:  if (r_cnt == SLOT_LAST && r_bit == 3'd7) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; the pulse toggles on the edge entering each half-slot.
    always_comb begin
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_bit_nxt   = r_bit;
        w_latch_nxt = 1'b0;
        w_pulse_nxt = 1'b0;
        w_capture   = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt   = '0;
                w_latch_nxt = vSyncStart;
            end
            S_LATCH: begin
                w_latch_nxt = (r_cnt != LATCH_LAST);
                if (r_cnt == LATCH_LAST) begin
                    w_cnt_nxt = '0;
                    w_bit_nxt = 3'd0;
                end
            end
            S_SHIFT: begin
                w_pulse_nxt = r_pad_pulse;
                if (r_cnt == HALF_LAST) begin
                    w_capture   = 1'b1;
                    w_pulse_nxt = 1'b1;
                end
                if (r_cnt == SLOT_LAST) begin
                    w_pulse_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = r_bit + 3'd1;
                end
            end
            S_COMMIT: begin
                w_cnt_nxt = '0;
                w_commit  = 1'b1;
            end
            default: w_cnt_nxt = '0;
        endcase
    end

    always_ff @(posedge pixelClock or posedge reset) begin
        if (reset) begin
            r_cnt         <= '0;
            r_bit         <= '0;
            r_sync1       <= '0;
            r_sync2       <= '0;
            r_shadow0     <= '0;
            r_shadow1     <= '0;
            r_pad_latch   <= 1'b0;
            r_pad_pulse   <= 1'b0;
            r_buttons0    <= '0;
            r_buttons1    <= '0;
            r_pressed0    <= '0;
            r_pressed1    <= '0;
            r_frame_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_bit         <= w_bit_nxt;
            r_sync1       <= padData;
            r_sync2       <= r_sync1;
            r_pad_latch   <= w_latch_nxt;
            r_pad_pulse   <= w_pulse_nxt;
            r_frame_valid <= w_commit;
            r_busy        <= (w_state_nxt != S_IDLE);
            // Pad data is active-low: a held button drives its line low.
            if (w_capture) begin
                r_shadow0[r_bit] <= ~r_sync2[0];
                r_shadow1[r_bit] <= ~r_sync2[1];
            end
            if (w_commit) begin
                r_buttons0 <= r_shadow0;
                r_buttons1 <= r_shadow1;
                r_pressed0 <= r_shadow0 & ~r_buttons0;
                r_pressed1 <= r_shadow1 & ~r_buttons1;
            end
            if (vSyncStart && r_state != S_IDLE) r_overrun <= 1'b1;
        end
    end

    assign padLatch   = r_pad_latch;
    assign padPulse   = r_pad_pulse;
    assign buttons0   = r_buttons0;
    assign buttons1   = r_buttons1;
    assign pressed0   = r_pressed0;
    assign pressed1   = r_pressed1;
    assign frameValid = r_frame_valid;
    assign busy       = r_busy;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_nes_dual_pad_scheduler.sv
// Directed bench for nes_dual_pad_scheduler with a behavioural pair of NES pads.
module tb_nes_dual_pad_scheduler;

    logic       pixelClock = 1'b0;
    logic       reset      = 1'b1;
    logic       vSyncStart = 1'b0;
    logic [1:0] padData;
    logic       padLatch;
    logic       padPulse;
    logic [7:0] buttons0;
    logic [7:0] buttons1;
    logic [7:0] pressed0;
    logic [7:0] pressed1;
    logic       frameValid;
    logic       busy;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    logic [7:0] pat0 = 8'h00;
    logic [7:0] pat1 = 8'h00;
    logic [7:0] sr0  = 8'h00;
    logic [7:0] sr1  = 8'h00;
    logic       pulse_q = 1'b0;

    nes_dual_pad_scheduler dut (
        .pixelClock (pixelClock),
        .reset      (reset),
        .vSyncStart (vSyncStart),
        .padData    (padData),
        .padLatch   (padLatch),
        .padPulse   (padPulse),
        .buttons0   (buttons0),
        .buttons1   (buttons1),
        .pressed0   (pressed0),
        .pressed1   (pressed1),
        .frameValid (frameValid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 pixelClock = ~pixelClock;

    // Pad model: latch loads the button byte, each falling pulse shifts the next button out.
    always @(posedge pixelClock) begin
        pulse_q <= padPulse;
        if (padLatch) begin
            sr0 <= pat0;
            sr1 <= pat1;
        end else if (pulse_q && !padPulse) begin
            sr0 <= sr0 >> 1;
            sr1 <= sr1 >> 1;
        end
    end
    assign padData = {~sr1[0], ~sr0[0]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One read from strobe to past commit; n counts edges after the strobe-sampling edge.
    task automatic run_frame(input logic [7:0] p0, input logic [7:0] p1, input int inject_at,
                             input logic [7:0] eb0, input logic [7:0] eb1,
                             input logic [7:0] ep0, input logic [7:0] ep1, input logic eovr);
        int fv_at, fv_cnt, latch_hi, rises, run, run_min, run_max;
        logic prev_pulse;
        logic [7:0] old_b0, pre_b0;
        fv_at = -1; fv_cnt = 0; latch_hi = 0; rises = 0; run = 0;
        run_min = 99999; run_max = 0; prev_pulse = 1'b0; pre_b0 = 8'hxx;
        pat0 = p0;
        pat1 = p1;
        @(negedge pixelClock);
        old_b0 = buttons0;
        vSyncStart = 1'b1;
        @(posedge pixelClock);
        #1 vSyncStart = 1'b0;
        for (int n = 0; n <= 4330; n++) begin
            if (n > 0) begin
                @(posedge pixelClock);
                #1;
            end
            if (inject_at > 0) vSyncStart = (n == inject_at);
            if (padLatch) latch_hi++;
            if (padPulse) begin
                if (!prev_pulse) rises++;
                run++;
            end else if (run > 0) begin
                if (run < run_min) run_min = run;
                if (run > run_max) run_max = run;
                run = 0;
            end
            prev_pulse = padPulse;
            if (n == 4320) pre_b0 = buttons0;
            if (frameValid) begin
                fv_cnt++;
                if (fv_at < 0) begin
                    fv_at = n;
                    check("buttons0_at_fv", 32'(buttons0), 32'(eb0));
                    check("buttons1_at_fv", 32'(buttons1), 32'(eb1));
                end
            end
        end
        check("fv_latency", 32'(fv_at), 32'd4321);
        check("fv_count", 32'(fv_cnt), 32'd1);
        check("b0_before_fv", 32'(pre_b0), 32'(old_b0));
        check("latch_cycles", 32'(latch_hi), 32'd480);
        check("pulse_count", 32'(rises), 32'd8);
        check("pulse_min", 32'(run_min), 32'd240);
        check("pulse_max", 32'(run_max), 32'd240);
        check("pressed0", 32'(pressed0), 32'(ep0));
        check("pressed1", 32'(pressed1), 32'(ep1));
        check("overrun", 32'(overrun), 32'(eovr));
        check("busy_end", 32'(busy), 32'd0);
    endtask

    initial begin
        int bad_idle;
        int fv_seen;
        // Reset, then 100 idle cycles with no strobe
        repeat (3) @(posedge pixelClock);
        @(negedge pixelClock);
        reset = 1'b0;
        bad_idle = 0;
        repeat (100) begin
            @(negedge pixelClock);
            if (padLatch || padPulse || busy || frameValid) bad_idle++;
        end
        check("idle_lines", 32'(bad_idle), 32'd0);
        check("idle_outputs", 32'({buttons0, buttons1, pressed0, pressed1, overrun}), 32'd0);

        // Frame sequence: new presses, releases, all-pressed on both pads
        run_frame(8'h81, 8'h00, 0, 8'h81, 8'h00, 8'h81, 8'h00, 1'b0);
        run_frame(8'h83, 8'h00, 0, 8'h83, 8'h00, 8'h02, 8'h00, 1'b0);
        run_frame(8'h01, 8'h00, 0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
        run_frame(8'hFF, 8'hFF, 0, 8'hFF, 8'hFF, 8'hFE, 8'hFF, 1'b0);

        // Strobe 1000 cycles into a read: ignored, overrun sticks
        run_frame(8'h5A, 8'hA5, 1000, 8'h5A, 8'hA5, 8'h00, 8'h00, 1'b1);
        run_frame(8'h11, 8'h22, 0, 8'h11, 8'h22, 8'h01, 8'h02, 1'b1);

        // Reset in the middle of shift slot 4
        pat0 = 8'h3C;
        pat1 = 8'hC3;
        @(negedge pixelClock);
        vSyncStart = 1'b1;
        @(posedge pixelClock);
        #1 vSyncStart = 1'b0;
        repeat (2500) @(posedge pixelClock);
        #1;
        check("busy_mid_read", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset_outputs",
              32'({buttons0, buttons1, pressed0, pressed1, overrun, busy, padLatch, padPulse, frameValid}),
              32'd0);
        repeat (10) @(posedge pixelClock);
        @(negedge pixelClock);
        reset = 1'b0;
        fv_seen = 0;
        repeat (5000) begin
            @(negedge pixelClock);
            if (frameValid || busy) fv_seen++;
        end
        check("no_fv_after_abort", 32'(fv_seen), 32'd0);
        run_frame(8'h3C, 8'hC3, 0, 8'h3C, 8'hC3, 8'h3C, 8'hC3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
